// File: rtl/keypad_scanner_if.sv
// Keypad pins plus the debounced key outputs that feed the game core.
// The scanner drives the column lines and key outputs; the keypad side drives the rows.
// Rows are active-low contacts, columns are active-low one-hot drive.
interface keypad_scanner_if;
  logic [3:0] kypd_row;
  logic [3:0] kypd_col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_press;
  logic [3:0] col_sel;
  logic       multi_key;

  modport master (
    input  kypd_row,
    output kypd_col,
    output key_code,
    output key_valid,
    output key_press,
    output col_sel,
    output multi_key
  );

  modport slave (
    output kypd_row,
    input  kypd_col,
    input  key_code,
    input  key_valid,
    input  key_press,
    input  col_sel,
    input  multi_key
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column scan, whole-scan debounce, press strobe and game-column map.
// Latency: outputs change one cycle after the COL3 sample that completes the debounce.
// No backpressure: key_press is a one-cycle strobe the game core must take when it fires.
module keypad_scanner #(
  parameter int SCAN_CYCLES    = 100000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int CNT_W          = 17
) (
  input  logic               clk,
  input  logic               reset,
  keypad_scanner_if.master   kp
);

  localparam logic [1:0] COL0 = 2'd0;
  localparam logic [1:0] COL1 = 2'd1;
  localparam logic [1:0] COL2 = 2'd2;
  localparam logic [1:0] COL3 = 2'd3;

  localparam logic [1:0] RES_NONE   = 2'd0;
  localparam logic [1:0] RES_SINGLE = 2'd1;
  localparam logic [1:0] RES_MULTI  = 2'd2;

  localparam int DB_W = $clog2(DEBOUNCE_SCANS + 1);

  // Hex legend of the Pmod keypad, indexed by driven column and contacted row.
  function automatic logic [3:0] key_map(input logic [1:0] col, input logic [1:0] row);
    logic [3:0] k;
    case ({col, row})
      4'h0: k = 4'h1;  4'h1: k = 4'h4;  4'h2: k = 4'h7;  4'h3: k = 4'h0;
      4'h4: k = 4'h2;  4'h5: k = 4'h5;  4'h6: k = 4'h8;  4'h7: k = 4'hF;
      4'h8: k = 4'h3;  4'h9: k = 4'h6;  4'hA: k = 4'h9;  4'hB: k = 4'hE;
      4'hC: k = 4'hA;  4'hD: k = 4'hB;  4'hE: k = 4'hC;  default: k = 4'hD;
    endcase
    return k;
  endfunction

  // Keys '1'..'7' select board columns 0..6; everything else is a code the game rejects.
  function automatic logic [3:0] code_to_col(input logic [3:0] code);
    logic [3:0] c;
    if (code >= 4'h1 && code <= 4'h7) c = code - 4'h1;
    else                              c = 4'hF;
    return c;
  endfunction

  logic [1:0]       state;
  logic [CNT_W-1:0] dwell_cnt;
  logic [1:0]       acc_cnt;    // contacts seen so far this scan, saturating at 2
  logic [3:0]       acc_code;   // code of the single contact, if exactly one so far
  logic [1:0]       prev_kind;
  logic [3:0]       prev_code;
  logic [1:0]       stable_kind;
  logic [3:0]       stable_code;
  logic [DB_W-1:0]  db_cnt;

  logic [3:0]       contacts;
  logic             last_dwell;
  logic [2:0]       hits;
  logic [1:0]       hit_row;
  logic [2:0]       sum;
  logic [1:0]       tot;
  logic [3:0]       merged_code;
  logic [1:0]       res_kind;
  logic [3:0]       res_code;
  logic             res_same;
  logic [DB_W-1:0]  db_next;
  logic             commit;
  logic             scan_done;

  assign kp.kypd_col = ~(4'b0001 << state);

  // Fold the current column's contacts into the running scan result and run the debounce math.
  always_comb begin
    contacts   = ~kp.kypd_row;
    last_dwell = (dwell_cnt == CNT_W'(SCAN_CYCLES - 1));
    scan_done  = last_dwell && (state == COL3);
    hits       = 3'($countones(contacts));
    hit_row    = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (contacts[r]) hit_row = 2'(r);
    end
    sum = {1'b0, acc_cnt} + ((hits >= 3'd2) ? 3'd2 : hits);
    tot = (sum >= 3'd2) ? 2'd2 : sum[1:0];
    if (acc_cnt == 2'd0 && hits == 3'd1) merged_code = key_map(state, hit_row);
    else                                 merged_code = acc_code;

    if (tot == 2'd0) begin
      res_kind = RES_NONE;
      res_code = 4'h0;
    end else if (tot == 2'd1) begin
      res_kind = RES_SINGLE;
      res_code = merged_code;
    end else begin
      res_kind = RES_MULTI;
      res_code = 4'h0;
    end

    res_same = (res_kind == prev_kind) && (res_code == prev_code);
    if (!res_same)                                     db_next = DB_W'(1);
    else if (db_cnt == DB_W'(DEBOUNCE_SCANS))          db_next = db_cnt;
    else                                               db_next = db_cnt + DB_W'(1);
    commit = (db_next == DB_W'(DEBOUNCE_SCANS)) &&
             ((res_kind != stable_kind) || (res_code != stable_code));
  end

  // Column scan: dwell on each column, sample rows on the last dwell cycle, then advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= COL0;
      dwell_cnt <= '0;
      acc_cnt   <= 2'd0;
      acc_code  <= 4'h0;
    end else if (last_dwell) begin
      dwell_cnt <= '0;
      case (state)
        COL0:    state <= COL1;
        COL1:    state <= COL2;
        COL2:    state <= COL3;
        default: state <= COL0;
      endcase
      if (state == COL3) begin
        acc_cnt  <= 2'd0;
        acc_code <= 4'h0;
      end else begin
        acc_cnt  <= tot;
        acc_code <= merged_code;
      end
    end else begin
      dwell_cnt <= dwell_cnt + CNT_W'(1);
    end
  end

  // Debounce whole-scan results and apply the effects of a committed stable-state change.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_kind    <= RES_NONE;
      prev_code    <= 4'h0;
      stable_kind  <= RES_NONE;
      stable_code  <= 4'h0;
      db_cnt       <= '0;
      kp.key_code  <= 4'h0;
      kp.key_valid <= 1'b0;
      kp.key_press <= 1'b0;
      kp.col_sel   <= 4'hF;
      kp.multi_key <= 1'b0;
    end else begin
      kp.key_press <= 1'b0;
      if (scan_done) begin
        db_cnt <= db_next;
        if (!res_same) begin
          prev_kind <= res_kind;
          prev_code <= res_code;
        end
        if (commit) begin
          stable_kind <= res_kind;
          stable_code <= res_code;
          case (res_kind)
            RES_SINGLE: begin
              kp.key_code  <= res_code;
              kp.col_sel   <= code_to_col(res_code);
              kp.key_valid <= 1'b1;
              kp.multi_key <= 1'b0;
              // Only a press out of a debounced idle counts as a new move.
              kp.key_press <= (stable_kind == RES_NONE);
            end
            RES_MULTI: begin
              kp.key_valid <= 1'b0;
              kp.multi_key <= 1'b1;
            end
            default: begin
              kp.key_valid <= 1'b0;
              kp.multi_key <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with a 4-cycle dwell and 2-scan debounce (16-cycle scans).
// A keypad model pulls rows low for held keys on the driven column; vectors hold a key set
// for a number of scans and the expected outputs are checked at the following scan boundary.
module tb_keypad_scanner;
  localparam int SC   = 4;
  localparam int SCAN = 4 * SC;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [15:0] keys = 16'h0;   // bit k set = key with hex legend k held down

  keypad_scanner_if bus ();

  keypad_scanner #(.SCAN_CYCLES(SC), .DEBOUNCE_SCANS(2), .CNT_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] keys;
    int          scans;
    logic [3:0]  code;
    logic        valid;
    logic        multi;
    logic [3:0]  csel;
    int          presses;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_vec = 0;
  int   n_fail = 0;
  int   press_cnt = 0;
  logic last_press = 1'b0;

  function automatic logic [3:0] legend(input int c, input int r);
    logic [3:0] t [4][4];
    t[0] = '{4'h1, 4'h4, 4'h7, 4'h0};
    t[1] = '{4'h2, 4'h5, 4'h8, 4'hF};
    t[2] = '{4'h3, 4'h6, 4'h9, 4'hE};
    t[3] = '{4'hA, 4'hB, 4'hC, 4'hD};
    return t[c][r];
  endfunction

  // Physical keypad: a held key shorts its row to the driven (low) column line.
  always_comb begin
    bus.kypd_row = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!bus.kypd_col[c] && keys[legend(c, r)]) bus.kypd_row[r] = 1'b0;
  end

  // Count press strobes and flag any strobe wider than one cycle.
  always @(negedge clk) begin
    if (bus.key_press) begin
      press_cnt++;
      n_vec++;
      if (last_press) begin
        n_fail++;
        $display("FAIL press_width: key_press high 2 cycles, required 1");
      end
    end
    last_press = bus.key_press;
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] k(input int code);
    return 16'h1 << code;
  endfunction

  function automatic void add(input logic [15:0] ks, input int sc, input logic [3:0] code,
                              input logic v, input logic m, input logic [3:0] cs, input int p);
    vec_t x;
    x.keys = ks; x.scans = sc; x.code = code; x.valid = v;
    x.multi = m; x.csel = cs; x.presses = p;
    vecs.push_back(x);
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    keys  = 16'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    #1;
  endtask

  initial begin
    vec_t e;
    logic [3:0] want;

    //   keys           scans code valid multi csel presses
    add(16'h0,          2, 4'h0, 0, 0, 4'hF, 0);
    add(k(5),           1, 4'h0, 0, 0, 4'hF, 0);
    add(k(5),           1, 4'h5, 1, 0, 4'h4, 1);
    add(k(5),           3, 4'h5, 1, 0, 4'h4, 0);
    add(16'h0,          1, 4'h5, 1, 0, 4'h4, 0);
    add(16'h0,          1, 4'h5, 0, 0, 4'h4, 0);
    add(k(10),          3, 4'hA, 1, 0, 4'hF, 1);
    add(16'h0,          2, 4'hA, 0, 0, 4'hF, 0);
    add(k(7),           3, 4'h7, 1, 0, 4'h6, 1);
    add(16'h0,          2, 4'h7, 0, 0, 4'h6, 0);
    add(k(1),           3, 4'h1, 1, 0, 4'h0, 1);
    add(16'h0,          2, 4'h1, 0, 0, 4'h0, 0);
    add(k(3),           1, 4'h1, 0, 0, 4'h0, 0);
    add(16'h0,          1, 4'h1, 0, 0, 4'h0, 0);
    add(k(3),           1, 4'h1, 0, 0, 4'h0, 0);
    add(16'h0,          2, 4'h1, 0, 0, 4'h0, 0);
    add(k(2) | k(9),    3, 4'h1, 0, 1, 4'h0, 0);
    add(k(2),           2, 4'h2, 1, 0, 4'h1, 0);
    add(16'h0,          2, 4'h2, 0, 0, 4'h1, 0);
    add(k(2),           3, 4'h2, 1, 0, 4'h1, 1);
    add(k(2) | k(9),    2, 4'h2, 0, 1, 4'h1, 0);
    add(16'h0,          2, 4'h2, 0, 0, 4'h1, 0);
    add(k(4),           3, 4'h4, 1, 0, 4'h3, 1);
    add(k(6),           3, 4'h6, 1, 0, 4'h5, 0);
    add(16'h0,          2, 4'h6, 0, 0, 4'h5, 0);
    add(k(0),           3, 4'h0, 1, 0, 4'hF, 1);
    add(16'h0,          2, 4'h0, 0, 0, 4'hF, 0);
    add(k(1) | k(4),    2, 4'h0, 0, 1, 4'hF, 0);
    add(16'h0,          2, 4'h0, 0, 0, 4'hF, 0);

    // Reset state and one idle scan of column drive.
    do_reset();
    check("rst.key_code",  bus.key_code,  0);
    check("rst.key_valid", bus.key_valid, 0);
    check("rst.key_press", bus.key_press, 0);
    check("rst.col_sel",   bus.col_sel,   4'hF);
    check("rst.multi_key", bus.multi_key, 0);
    for (int i = 0; i < SCAN; i++) begin
      if (i > 0) @(negedge clk);
      want = ~(4'b0001 << (i / SC));
      check($sformatf("scan.col%0d", i), bus.kypd_col, want);
    end

    // Reset in the middle of COL2 restarts at column 0 with a cleared dwell counter.
    repeat (10) @(negedge clk);
    check("mid.col2", bus.kypd_col, 4'b1011);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i <= SC; i++) begin
      @(negedge clk);
      want = (i < SC) ? 4'b1110 : 4'b1101;
      check($sformatf("mid.after%0d", i), bus.kypd_col, want);
    end
    check("mid.key_valid", bus.key_valid, 0);

    // Table-driven key sequences.
    do_reset();
    foreach (vecs[i]) begin
      keys = vecs[i].keys;
      press_cnt = 0;
      exp_q.push_back(vecs[i]);
      repeat (vecs[i].scans * SCAN) @(posedge clk);
      @(negedge clk);
      #1;
      e = exp_q.pop_front();
      check($sformatf("v%0d.key_code", i),  bus.key_code,  e.code);
      check($sformatf("v%0d.key_valid", i), bus.key_valid, e.valid);
      check($sformatf("v%0d.multi_key", i), bus.multi_key, e.multi);
      check($sformatf("v%0d.col_sel", i),   bus.col_sel,   e.csel);
      check($sformatf("v%0d.presses", i),   press_cnt,     e.presses);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
